// File: rtl/fanout_fork_if.sv
// fanout_fork_if: producer, consumer and configuration signals of the fanout fork controller.
interface fanout_fork_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic         cfg_en;
  logic [N-1:0] cfg_mask;
  logic         cfg_ready;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [N-1:0] out_valid;
  logic [W-1:0] out_data;
  logic [N-1:0] out_ready;
  logic         busy;
  logic [15:0]  stall_cnt;
  logic [15:0]  tok_cnt;
  modport slave (
    input  cfg_en, cfg_mask, flush, in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_data, busy, stall_cnt, tok_cnt
  );
  modport master (
    output cfg_en, cfg_mask, flush, in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, busy, stall_cnt, tok_cnt
  );
endinterface

// File: rtl/fanout_fork_ctrl.sv
// fanout_fork_ctrl: eager fork of one producer stream to N consumers with per-consumer done tracking.
module fanout_fork_ctrl #(
  parameter int N = 4,
  parameter int W = 32
) (
  input logic           clk,
  input logic           rst_n,
  fanout_fork_if.slave  bus
);
  typedef enum logic {IDLE, PARTIAL} state_t;
  state_t       r_state, w_state_nxt;
  logic [N-1:0] r_mask, r_done, w_done_nxt, w_valid, w_fire;
  logic         w_in_ready, w_consume, w_stall, w_cfg_acc;
  logic [15:0]  r_stall_cnt, r_tok_cnt;
  always_comb begin
    w_valid     = {N{bus.in_valid}} & r_mask & ~r_done;
    w_fire      = w_valid & bus.out_ready;
    w_in_ready  = bus.flush | (&(~r_mask | r_done | bus.out_ready));
    w_consume   = bus.in_valid & w_in_ready;
    w_stall     = bus.in_valid & ~w_in_ready;
    // rst_n gate keeps cfg_ready low while reset holds the block
    w_cfg_acc   = rst_n & bus.cfg_en & (r_state == IDLE) & ~|w_fire;
    w_done_nxt  = (w_consume | bus.flush) ? '0 : (r_done | w_fire);
    w_state_nxt = |w_done_nxt ? PARTIAL : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_done      <= '0;
      r_mask      <= '0;
      r_stall_cnt <= '0;
      r_tok_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_cfg_acc) r_mask <= bus.cfg_mask;
      r_stall_cnt <= w_cfg_acc ? '0 : r_stall_cnt + 16'(w_stall & ~&r_stall_cnt);
      r_tok_cnt   <= r_tok_cnt + 16'(w_consume & ~&r_tok_cnt);
    end
  end
  assign bus.cfg_ready = w_cfg_acc;
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = bus.in_data;
  assign bus.busy      = (r_state == PARTIAL);
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.tok_cnt   = r_tok_cnt;
endmodule

// File: tb/tb_fanout_fork_ctrl.sv
// tb_fanout_fork_ctrl: directed and randomized checks of the fanout fork against a consumer-set model.
module tb_fanout_fork_ctrl;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fanout_fork_if #(.N(N), .W(W)) bus();
  fanout_fork_ctrl #(.N(N), .W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0;
  int bad = 0;
  bit m_mask[N];
  bit m_taken[N];
  int m_stall;
  int m_tok;
  // A consumer is offered the token while it is enabled and has not yet received it
  function automatic logic [N-1:0] exp_valid();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = bus.in_valid && m_mask[i] && !m_taken[i];
    return v;
  endfunction
  function automatic bit exp_ready();
    if (bus.flush) return 1'b1;
    for (int i = 0; i < N; i++)
      if (m_mask[i] && !m_taken[i] && !bus.out_ready[i]) return 1'b0;
    return 1'b1;
  endfunction
  function automatic bit exp_partial();
    for (int i = 0; i < N; i++) if (m_taken[i]) return 1'b1;
    return 1'b0;
  endfunction
  function automatic bit exp_cfg_ready();
    return rst_n && bus.cfg_en && !exp_partial() && ((exp_valid() & bus.out_ready) == '0);
  endfunction
  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mask[i] = 1'b0;
      m_taken[i] = 1'b0;
    end
    m_stall = 0;
    m_tok = 0;
  endtask
  task automatic tick();
    logic [N-1:0] f;
    bit rdy, acc, cons;
    f = exp_valid() & bus.out_ready;
    rdy = exp_ready();
    acc = exp_cfg_ready();
    cons = bus.in_valid && rdy;
    @(posedge clk);
    if (acc) begin
      for (int i = 0; i < N; i++) m_mask[i] = bus.cfg_mask[i];
      m_stall = 0;
    end else if (bus.in_valid && !rdy) m_stall = sat(m_stall + 1);
    if (cons) m_tok = sat(m_tok + 1);
    for (int i = 0; i < N; i++) m_taken[i] = (cons || bus.flush) ? 1'b0 : (m_taken[i] || f[i]);
    @(negedge clk);
  endtask
  task automatic idle_inputs();
    bus.cfg_en = 1'b0;
    bus.cfg_mask = '0;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = $urandom;
    bus.out_ready = '0;
  endtask
  task automatic configure(input logic [N-1:0] m);
    idle_inputs();
    bus.cfg_en = 1'b1;
    bus.cfg_mask = m;
    tick();
    bus.cfg_en = 1'b0;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    idle_inputs();
    bus.cfg_en = 1'b1;
    bus.in_valid = 1'b1;
    bus.out_ready = '1;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== '0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL reset_cfg_ready got=%b exp=0", bus.cfg_ready); end
    total++; if (bus.stall_cnt !== 16'd0 || bus.tok_cnt !== 16'd0) begin bad++; $display("FAIL reset_counters got=%h/%h exp=0/0", bus.stall_cnt, bus.tok_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.cfg_en = 1'b0;
    #1;
    total++; if (bus.out_valid !== '0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_sink got=%b/%b exp=0000/1", bus.out_valid, bus.in_ready); end
    tick();
    total++; if (bus.tok_cnt !== 16'(m_tok) || m_tok != 1) begin bad++; $display("FAIL post_reset_tok got=%0d exp=1", bus.tok_cnt); end
  endtask
  task automatic test_lockstep();
    configure(4'b1111);
    bus.out_ready = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data = $urandom;
      #1;
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL lockstep_in_ready[%0d] got=%b exp=1", k, bus.in_ready); end
      total++; if (bus.out_data !== bus.in_data) begin bad++; $display("FAIL lockstep_data got=%h exp=%h", bus.out_data, bus.in_data); end
      tick();
    end
    idle_inputs();
    #1;
    total++; if (bus.tok_cnt !== 16'(m_tok)) begin bad++; $display("FAIL lockstep_tok got=%0d exp=%0d", bus.tok_cnt, m_tok); end
    total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL lockstep_stall got=%0d exp=0", bus.stall_cnt); end
  endtask
  task automatic test_staggered();
    logic [N-1:0] rdy_seq [3] = '{4'b0001, 4'b0010, 4'b0100};
    logic [N-1:0] ov_seq  [3] = '{4'b0111, 4'b0110, 4'b0100};
    bit busy_seq [3] = '{1'b0, 1'b1, 1'b1};
    bit ir_seq   [3] = '{1'b0, 1'b0, 1'b1};
    configure(4'b0111);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.out_ready = rdy_seq[k];
      #1;
      total++; if (bus.out_valid !== ov_seq[k]) begin bad++; $display("FAIL stagger_out_valid[%0d] got=%b exp=%b", k, bus.out_valid, ov_seq[k]); end
      total++; if (bus.busy !== busy_seq[k]) begin bad++; $display("FAIL stagger_busy[%0d] got=%b exp=%b", k, bus.busy, busy_seq[k]); end
      total++; if (bus.in_ready !== ir_seq[k]) begin bad++; $display("FAIL stagger_in_ready[%0d] got=%b exp=%b", k, bus.in_ready, ir_seq[k]); end
      tick();
    end
    idle_inputs();
    #1;
    total++; if (bus.stall_cnt !== 16'd2) begin bad++; $display("FAIL stagger_stall got=%0d exp=2", bus.stall_cnt); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stagger_idle got=%b exp=0", bus.busy); end
  endtask
  task automatic test_masked();
    configure(4'b0101);
    bus.in_valid = 1'b1;
    bus.out_ready = 4'b0101;
    #1;
    total++; if (bus.out_valid !== 4'b0101) begin bad++; $display("FAIL masked_out_valid got=%b exp=0101", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL masked_in_ready got=%b exp=1", bus.in_ready); end
    tick();
    idle_inputs();
  endtask
  task automatic test_cfg_partial();
    configure(4'b1111);
    bus.in_valid = 1'b1;
    bus.out_ready = 4'b0001;
    tick();
    bus.out_ready = '0;
    bus.cfg_en = 1'b1;
    bus.cfg_mask = 4'b0011;
    #1;
    total++; if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL cfg_partial_ready got=%b exp=0", bus.cfg_ready); end
    tick();
    bus.cfg_en = 1'b0;
    #1;
    total++; if (bus.out_valid !== 4'b1110) begin bad++; $display("FAIL cfg_partial_mask got=%b exp=1110", bus.out_valid); end
    bus.out_ready = 4'b1110;
    tick();
    bus.out_ready = '0;
    bus.cfg_en = 1'b1;
    #1;
    total++; if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL cfg_idle_ready got=%b exp=1", bus.cfg_ready); end
    tick();
    bus.cfg_en = 1'b0;
    #1;
    total++; if (bus.out_valid !== 4'b0011) begin bad++; $display("FAIL cfg_new_mask got=%b exp=0011", bus.out_valid); end
    total++; if (bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL cfg_stall_clear got=%0d exp=0", bus.stall_cnt); end
    idle_inputs();
  endtask
  task automatic test_flush();
    int tok0;
    configure(4'b1111);
    bus.in_valid = 1'b1;
    bus.out_ready = 4'b0011;
    tick();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy got=%b exp=1", bus.busy); end
    tok0 = m_tok;
    bus.out_ready = '0;
    bus.flush = 1'b1;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); end
    tick();
    bus.flush = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.out_valid !== 4'b1111) begin bad++; $display("FAIL flush_clear got=%b/%b exp=0/1111", bus.busy, bus.out_valid); end
    total++; if (bus.tok_cnt !== 16'(tok0 + 1)) begin bad++; $display("FAIL flush_tok got=%0d exp=%0d", bus.tok_cnt, tok0 + 1); end
    bus.out_ready = 4'b0100;
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = '0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.tok_cnt !== 16'(tok0 + 1)) begin bad++; $display("FAIL flush_novalid got=%b/%0d exp=0/%0d", bus.busy, bus.tok_cnt, tok0 + 1); end
    idle_inputs();
  endtask
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      bus.in_valid = exp_partial() ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      bus.in_data = $urandom;
      bus.out_ready = N'($urandom);
      bus.flush = ($urandom_range(0, 15) == 0);
      bus.cfg_en = ($urandom_range(0, 5) == 0);
      bus.cfg_mask = N'($urandom);
      #1;
      total++; if (bus.out_valid !== exp_valid()) begin bad++; $display("FAIL rnd_out_valid[%0d] got=%b exp=%b", k, bus.out_valid, exp_valid()); end
      total++; if (bus.in_ready !== exp_ready()) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", k, bus.in_ready, exp_ready()); end
      total++; if (bus.cfg_ready !== exp_cfg_ready()) begin bad++; $display("FAIL rnd_cfg_ready[%0d] got=%b exp=%b", k, bus.cfg_ready, exp_cfg_ready()); end
      total++; if (bus.busy !== exp_partial()) begin bad++; $display("FAIL rnd_busy[%0d] got=%b exp=%b", k, bus.busy, exp_partial()); end
      total++; if (bus.out_data !== bus.in_data) begin bad++; $display("FAIL rnd_data[%0d] got=%h exp=%h", k, bus.out_data, bus.in_data); end
      total++; if (bus.stall_cnt !== 16'(m_stall) || bus.tok_cnt !== 16'(m_tok)) begin bad++; $display("FAIL rnd_counters[%0d] got=%0d/%0d exp=%0d/%0d", k, bus.stall_cnt, bus.tok_cnt, m_stall, m_tok); end
      tick();
    end
    idle_inputs();
  endtask
  task automatic test_reset_partial();
    configure(4'b1111);
    bus.in_valid = 1'b1;
    bus.out_ready = 4'b0011;
    tick();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rstp_pre_busy got=%b exp=1", bus.busy); end
    bus.out_ready = '0;
    bus.cfg_en = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (bus.out_valid !== '0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL rstp_outputs got=%b/%b exp=0000/1", bus.out_valid, bus.in_ready); end
    total++; if (bus.busy !== 1'b0 || bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL rstp_busy_cfg got=%b/%b exp=0/0", bus.busy, bus.cfg_ready); end
    total++; if (bus.tok_cnt !== 16'd0 || bus.stall_cnt !== 16'd0) begin bad++; $display("FAIL rstp_counters got=%0d/%0d exp=0/0", bus.tok_cnt, bus.stall_cnt); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask
  task automatic test_saturation();
    do_reset();
    configure(4'b0001);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 70000; k++) tick();
    #1;
    total++; if (bus.stall_cnt !== 16'hFFFF || m_stall != 65535) begin bad++; $display("FAIL stall_sat got=%h exp=ffff", bus.stall_cnt); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stall_sat_busy got=%b exp=0", bus.busy); end
    idle_inputs();
  endtask
  initial begin
    idle_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    test_lockstep();
    test_staggered();
    test_masked();
    test_cfg_partial();
    test_flush();
    test_random();
    test_reset_partial();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
